// File: rtl/kamacore_pkg.sv
// rtl/kamacore_pkg.sv - shared core constants, decode enums and control bundle
// Contents:
//   CPU_WIDTH, REG_ADDR_WIDTH  default datapath / register address widths
//   e_opcode, e_alu_op, e_imm_sel  RV32I decode enumerations
//   st_control_signals         decoded control bundle passed ID->EX
//   alu_decode()               funct3/alt-bit to ALU operation
package kamacore_pkg;

  localparam int CPU_WIDTH      = 32;
  localparam int REG_ADDR_WIDTH = 5;

  typedef enum logic [6:0] {
    OPC_LOAD   = 7'b0000011,
    OPC_OP_IMM = 7'b0010011,
    OPC_AUIPC  = 7'b0010111,
    OPC_STORE  = 7'b0100011,
    OPC_OP     = 7'b0110011,
    OPC_LUI    = 7'b0110111,
    OPC_BRANCH = 7'b1100011,
    OPC_JALR   = 7'b1100111,
    OPC_JAL    = 7'b1101111
  } e_opcode;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_SLL    = 4'd2,
    ALU_SLT    = 4'd3,
    ALU_SLTU   = 4'd4,
    ALU_XOR    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_OR     = 4'd8,
    ALU_AND    = 4'd9,
    ALU_PASS_B = 4'd10
  } e_alu_op;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } e_imm_sel;

  typedef struct packed {
    e_alu_op  alu_op;
    e_imm_sel imm_sel;
    logic     alu_src_imm;
    logic     alu_src_pc;
    logic     mem_read;
    logic     mem_write;
    logic     reg_write;
    logic     mem_to_reg;
    logic     branch;
    logic     jump;
    logic     illegal;
  } st_control_signals;

  // alt selects SUB over ADD and SRA over SRL (instruction bit 30).
  function automatic e_alu_op alu_decode(input logic [2:0] funct3, input logic alt);
    case (funct3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/kamacore_control_unit.sv
// rtl/kamacore_control_unit.sv - combinational RV32I main decoder
// Ports:
//   instruction  32-bit instruction word
//   ctrl         decoded st_control_signals; unknown opcodes raise ctrl.illegal
module kamacore_control_unit
  import kamacore_pkg::*;
(
  input  logic [31:0]       instruction,
  output st_control_signals ctrl
);

  logic [2:0] funct3;
  logic       bit30;

  assign funct3 = instruction[14:12];
  assign bit30  = instruction[30];

  always_comb begin
    ctrl         = '0;
    ctrl.alu_op  = ALU_ADD;
    ctrl.imm_sel = IMM_NONE;
    case (instruction[6:0])
      OPC_LOAD: begin
        ctrl.imm_sel     = IMM_I;
        ctrl.alu_src_imm = 1'b1;
        ctrl.mem_read    = 1'b1;
        ctrl.reg_write   = 1'b1;
        ctrl.mem_to_reg  = 1'b1;
      end
      OPC_STORE: begin
        ctrl.imm_sel     = IMM_S;
        ctrl.alu_src_imm = 1'b1;
        ctrl.mem_write   = 1'b1;
      end
      OPC_OP: begin
        ctrl.alu_op    = alu_decode(funct3, bit30);
        ctrl.reg_write = 1'b1;
      end
      OPC_OP_IMM: begin
        // bit 30 is immediate data except for the right-shift encoding
        ctrl.alu_op      = alu_decode(funct3, bit30 && (funct3 == 3'b101));
        ctrl.imm_sel     = IMM_I;
        ctrl.alu_src_imm = 1'b1;
        ctrl.reg_write   = 1'b1;
      end
      OPC_LUI: begin
        ctrl.alu_op      = ALU_PASS_B;
        ctrl.imm_sel     = IMM_U;
        ctrl.alu_src_imm = 1'b1;
        ctrl.reg_write   = 1'b1;
      end
      OPC_AUIPC: begin
        ctrl.imm_sel     = IMM_U;
        ctrl.alu_src_imm = 1'b1;
        ctrl.alu_src_pc  = 1'b1;
        ctrl.reg_write   = 1'b1;
      end
      OPC_BRANCH: begin
        ctrl.alu_op  = ALU_SUB;
        ctrl.imm_sel = IMM_B;
        ctrl.branch  = 1'b1;
      end
      OPC_JAL: begin
        ctrl.imm_sel    = IMM_J;
        ctrl.alu_src_pc = 1'b1;
        ctrl.jump       = 1'b1;
        ctrl.reg_write  = 1'b1;
      end
      OPC_JALR: begin
        ctrl.imm_sel     = IMM_I;
        ctrl.alu_src_imm = 1'b1;
        ctrl.jump        = 1'b1;
        ctrl.reg_write   = 1'b1;
      end
      default: ctrl.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/kamacore_operand_mux.sv
// rtl/kamacore_operand_mux.sv - source operand selection for one register read
// Ports:
//   rs_a                                  register address being read
//   fwd_valid, fwd_rd_a, fwd_rd_data      forwarding channels, index 0 youngest
//   wb_rd_we, wb_rd_a, wb_rd_data         register file write port (write-through)
//   rf_data                               raw register file read data
//   operand                               selected value
// Priority: x0 -> zero, youngest matching forward, same-cycle WB write, file.
module kamacore_operand_mux #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_FWD    = 2
) (
  input  logic [ADDR_WIDTH-1:0]               rs_a,
  input  logic [NUM_FWD-1:0]                  fwd_valid,
  input  logic [NUM_FWD-1:0][ADDR_WIDTH-1:0]  fwd_rd_a,
  input  logic [NUM_FWD-1:0][DATA_WIDTH-1:0]  fwd_rd_data,
  input  logic                                wb_rd_we,
  input  logic [ADDR_WIDTH-1:0]               wb_rd_a,
  input  logic [DATA_WIDTH-1:0]               wb_rd_data,
  input  logic [DATA_WIDTH-1:0]               rf_data,
  output logic [DATA_WIDTH-1:0]               operand
);

  // Later assignments win, so sources are applied from lowest to highest
  // priority; the forward loop runs oldest-first so channel 0 ends up on top.
  always_comb begin
    operand = rf_data;
    if (wb_rd_we && (wb_rd_a == rs_a)) begin
      operand = wb_rd_data;
    end
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (fwd_valid[i] && (fwd_rd_a[i] == rs_a)) begin
        operand = fwd_rd_data[i];
      end
    end
    if (rs_a == '0) begin
      operand = '0;
    end
  end

endmodule

// File: rtl/kamacore_register_file.sv
// rtl/kamacore_register_file.sv - 2-read / 1-write integer register file
// Ports:
//   clk, rst            clock, asynchronous active-low reset (clears all entries)
//   we, wa, wd          write port; writes to address 0 are dropped
//   ra1/rd1, ra2/rd2    combinational read ports (no internal bypass)
module kamacore_register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] wa,
  input  logic [DATA_WIDTH-1:0] wd,
  input  logic [ADDR_WIDTH-1:0] ra1,
  input  logic [ADDR_WIDTH-1:0] ra2,
  output logic [DATA_WIDTH-1:0] rd1,
  output logic [DATA_WIDTH-1:0] rd2
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (wa != '0)) begin
      regs[wa] <= wd;
    end
  end

  assign rd1 = regs[ra1];
  assign rd2 = regs[ra2];

endmodule

// File: rtl/kamacore_stage_id_hz.sv
// rtl/kamacore_stage_id_hz.sv - ID stage with operand forwarding and load-use hazard stall
// Ports:
//   clk, rst                              clock, asynchronous active-low reset
//   in_valid, in_ready, in_instruction    IF->ID handshake
//   out_valid, out_ready                  ID->EX handshake
//   out_instruction, out_rs1_data,
//   out_rs2_data, out_control_signals     registered decode results
//   fwd_valid, fwd_rd_a, fwd_rd_data      forwarding channels, index 0 youngest
//   ex_load_valid, ex_load_rd_a           load currently in EX and its destination
//   flush                                 drop held output and current input
//   wb_rd_we, wb_rd_a, wb_rd_data         register file write port
//   stall_count                           saturating count of load-use stall cycles
module kamacore_stage_id_hz
  import kamacore_pkg::*;
#(
  parameter int CPU_WIDTH      = kamacore_pkg::CPU_WIDTH,
  parameter int REG_ADDR_WIDTH = kamacore_pkg::REG_ADDR_WIDTH,
  parameter int NUM_FWD        = 2
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [31:0]                            in_instruction,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [31:0]                            out_instruction,
  output logic [CPU_WIDTH-1:0]                   out_rs1_data,
  output logic [CPU_WIDTH-1:0]                   out_rs2_data,
  output st_control_signals                      out_control_signals,
  input  logic [NUM_FWD-1:0]                     fwd_valid,
  input  logic [NUM_FWD-1:0][REG_ADDR_WIDTH-1:0] fwd_rd_a,
  input  logic [NUM_FWD-1:0][CPU_WIDTH-1:0]      fwd_rd_data,
  input  logic                                   ex_load_valid,
  input  logic [REG_ADDR_WIDTH-1:0]              ex_load_rd_a,
  input  logic                                   flush,
  input  logic                                   wb_rd_we,
  input  logic [REG_ADDR_WIDTH-1:0]              wb_rd_a,
  input  logic [CPU_WIDTH-1:0]                   wb_rd_data,
  output logic [15:0]                            stall_count
);

  typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} e_state;

  e_state                    state;
  logic [REG_ADDR_WIDTH-1:0] rs1_a;
  logic [REG_ADDR_WIDTH-1:0] rs2_a;
  logic [CPU_WIDTH-1:0]      rf_rd1;
  logic [CPU_WIDTH-1:0]      rf_rd2;
  logic [CPU_WIDTH-1:0]      rs1_data;
  logic [CPU_WIDTH-1:0]      rs2_data;
  st_control_signals         dec_ctrl;
  logic                      load_use;
  logic                      out_free;
  logic                      in_xfer;

  assign rs1_a = REG_ADDR_WIDTH'(in_instruction[19:15]);
  assign rs2_a = REG_ADDR_WIDTH'(in_instruction[24:20]);

  // Field match is on the raw rs1/rs2 slots, whether or not the opcode
  // actually reads them: a spurious bubble is cheaper than decoding here.
  assign load_use = in_valid && ex_load_valid && (ex_load_rd_a != '0) &&
                    ((ex_load_rd_a == rs1_a) || (ex_load_rd_a == rs2_a));

  assign out_free = (state == ST_EMPTY) || out_ready;
  assign in_ready = out_free && !load_use && !flush;
  assign in_xfer  = in_valid && in_ready;

  kamacore_register_file #(
    .DATA_WIDTH (CPU_WIDTH),
    .ADDR_WIDTH (REG_ADDR_WIDTH)
  ) u_register_file (
    .clk (clk),
    .rst (rst),
    .we  (wb_rd_we),
    .wa  (wb_rd_a),
    .wd  (wb_rd_data),
    .ra1 (rs1_a),
    .ra2 (rs2_a),
    .rd1 (rf_rd1),
    .rd2 (rf_rd2)
  );

  kamacore_control_unit u_control_unit (
    .instruction (in_instruction),
    .ctrl        (dec_ctrl)
  );

  kamacore_operand_mux #(
    .DATA_WIDTH (CPU_WIDTH),
    .ADDR_WIDTH (REG_ADDR_WIDTH),
    .NUM_FWD    (NUM_FWD)
  ) u_rs1_mux (
    .rs_a        (rs1_a),
    .fwd_valid   (fwd_valid),
    .fwd_rd_a    (fwd_rd_a),
    .fwd_rd_data (fwd_rd_data),
    .wb_rd_we    (wb_rd_we),
    .wb_rd_a     (wb_rd_a),
    .wb_rd_data  (wb_rd_data),
    .rf_data     (rf_rd1),
    .operand     (rs1_data)
  );

  kamacore_operand_mux #(
    .DATA_WIDTH (CPU_WIDTH),
    .ADDR_WIDTH (REG_ADDR_WIDTH),
    .NUM_FWD    (NUM_FWD)
  ) u_rs2_mux (
    .rs_a        (rs2_a),
    .fwd_valid   (fwd_valid),
    .fwd_rd_a    (fwd_rd_a),
    .fwd_rd_data (fwd_rd_data),
    .wb_rd_we    (wb_rd_we),
    .wb_rd_a     (wb_rd_a),
    .wb_rd_data  (wb_rd_data),
    .rf_data     (rf_rd2),
    .operand     (rs2_data)
  );

  // Output FSM. Data registers only move on a transfer, so a stalled FULL
  // stage holds them and a flush simply invalidates them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state               <= ST_EMPTY;
      out_valid           <= 1'b0;
      out_instruction     <= '0;
      out_rs1_data        <= '0;
      out_rs2_data        <= '0;
      out_control_signals <= '0;
    end else begin
      case (state)
        ST_EMPTY, ST_FULL: begin
          if (flush) begin
            state     <= ST_EMPTY;
            out_valid <= 1'b0;
          end else if (in_xfer) begin
            state               <= ST_FULL;
            out_valid           <= 1'b1;
            out_instruction     <= in_instruction;
            out_rs1_data        <= rs1_data;
            out_rs2_data        <= rs2_data;
            out_control_signals <= dec_ctrl;
          end else if (out_free) begin
            // Consumed (or already empty) with nothing new: insert a bubble.
            state     <= ST_EMPTY;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= ST_EMPTY;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_count <= '0;
    end else if (load_use && (stall_count != 16'hFFFF)) begin
      stall_count <= stall_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_kamacore_stage_id_hz.sv
// tb/tb_kamacore_stage_id_hz.sv - self-checking bench for kamacore_stage_id_hz
module tb_kamacore_stage_id_hz;
  import kamacore_pkg::*;

  logic                  clk;
  logic                  rst;
  logic                  in_valid;
  logic                  in_ready;
  logic [31:0]           in_instruction;
  logic                  out_valid;
  logic                  out_ready;
  logic [31:0]           out_instruction;
  logic [31:0]           out_rs1_data;
  logic [31:0]           out_rs2_data;
  st_control_signals     out_control_signals;
  logic [1:0]            fwd_valid;
  logic [1:0][4:0]       fwd_rd_a;
  logic [1:0][31:0]      fwd_rd_data;
  logic                  ex_load_valid;
  logic [4:0]            ex_load_rd_a;
  logic                  flush;
  logic                  wb_rd_we;
  logic [4:0]            wb_rd_a;
  logic [31:0]           wb_rd_data;
  logic [15:0]           stall_count;
  logic [15:0]           ctrl_bits;

  assign ctrl_bits = out_control_signals;

  kamacore_stage_id_hz dut (
    .clk                 (clk),
    .rst                 (rst),
    .in_valid            (in_valid),
    .in_ready            (in_ready),
    .in_instruction      (in_instruction),
    .out_valid           (out_valid),
    .out_ready           (out_ready),
    .out_instruction     (out_instruction),
    .out_rs1_data        (out_rs1_data),
    .out_rs2_data        (out_rs2_data),
    .out_control_signals (out_control_signals),
    .fwd_valid           (fwd_valid),
    .fwd_rd_a            (fwd_rd_a),
    .fwd_rd_data         (fwd_rd_data),
    .ex_load_valid       (ex_load_valid),
    .ex_load_rd_a        (ex_load_rd_a),
    .flush               (flush),
    .wb_rd_we            (wb_rd_we),
    .wb_rd_a             (wb_rd_a),
    .wb_rd_data          (wb_rd_data),
    .stall_count         (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid       = 1'b0;
    in_instruction = '0;
    out_ready      = 1'b1;
    fwd_valid      = '0;
    fwd_rd_a       = '0;
    fwd_rd_data    = '0;
    ex_load_valid  = 1'b0;
    ex_load_rd_a   = '0;
    flush          = 1'b0;
    wb_rd_we       = 1'b0;
    wb_rd_a        = '0;
    wb_rd_data     = '0;
  endtask

  function automatic logic [31:0] i_add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] i_lw(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, 3'b010, rd, 7'b0000011};
  endfunction

  function automatic logic [31:0] i_sw(input logic [4:0] rs2, input logic [4:0] rs1, input logic [11:0] imm);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [1:0]  fv;
    logic [4:0]  fa0;
    logic [31:0] fd0;
    logic [4:0]  fa1;
    logic [31:0] fd1;
    logic        wbwe;
    logic [4:0]  wba;
    logic [31:0] wbd;
    logic [31:0] e_rs1;
    logic [31:0] e_rs2;
    logic        e_rw;
    logic        e_mr;
    logic        e_mw;
  } vec_t;

  function automatic vec_t mk(input string name, input logic [31:0] instr,
                              input logic [1:0] fv, input logic [4:0] fa0, input logic [31:0] fd0,
                              input logic [4:0] fa1, input logic [31:0] fd1,
                              input logic wbwe, input logic [4:0] wba, input logic [31:0] wbd,
                              input logic [31:0] e_rs1, input logic [31:0] e_rs2,
                              input logic e_rw, input logic e_mr, input logic e_mw);
    vec_t v;
    v.name = name; v.instr = instr; v.fv = fv; v.fa0 = fa0; v.fd0 = fd0;
    v.fa1 = fa1; v.fd1 = fd1; v.wbwe = wbwe; v.wba = wba; v.wbd = wbd;
    v.e_rs1 = e_rs1; v.e_rs2 = e_rs2; v.e_rw = e_rw; v.e_mr = e_mr; v.e_mw = e_mw;
    return v;
  endfunction

  // Reference model state for the randomized phase
  logic [31:0] m_regs [32];
  logic        m_valid;
  logic [31:0] m_instr, m_rs1, m_rs2;
  int          m_stall;

  function automatic logic [31:0] m_operand(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    for (int i = 0; i < 2; i++) begin
      if (fwd_valid[i] && (fwd_rd_a[i] == a)) return fwd_rd_data[i];
    end
    if (wb_rd_we && (wb_rd_a == a)) return wb_rd_data;
    return m_regs[a];
  endfunction

  vec_t vecs [8];

  initial begin
    logic [31:0] instr_a, instr_b, instr_c;
    logic        lu, rdy;
    logic [4:0]  r1, r2;

    idle_inputs();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    tick();

    // Reset state
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_instruction", out_instruction, 0);
    chk("rst_out_rs1", out_rs1_data, 0);
    chk("rst_out_rs2", out_rs2_data, 0);
    chk("rst_ctrl", ctrl_bits, 0);
    chk("rst_stall_count", stall_count, 0);
    chk("rst_in_ready", in_ready, 1);

    // x5 = 0x11 through the write-back port
    wb_rd_we = 1'b1; wb_rd_a = 5'd5; wb_rd_data = 32'h11;
    tick();
    idle_inputs();

    vecs[0] = mk("add_rf",      i_add(5'd6, 5'd5, 5'd5), 2'b00, 5'd0, 32'h0,    5'd0, 32'h0, 1'b0, 5'd0, 32'h0,  32'h11, 32'h11, 1, 0, 0);
    vecs[1] = mk("fwd_prio",    i_add(5'd6, 5'd5, 5'd5), 2'b11, 5'd5, 32'hA,    5'd5, 32'hB, 1'b0, 5'd0, 32'h0,  32'hA,  32'hA,  1, 0, 0);
    vecs[2] = mk("fwd_ch1",     i_add(5'd6, 5'd5, 5'd5), 2'b10, 5'd0, 32'h0,    5'd5, 32'hB, 1'b0, 5'd0, 32'h0,  32'hB,  32'hB,  1, 0, 0);
    vecs[3] = mk("fwd_over_wb", i_add(5'd6, 5'd5, 5'd6), 2'b01, 5'd5, 32'hC,    5'd0, 32'h0, 1'b1, 5'd5, 32'h33, 32'hC,  32'h0,  1, 0, 0);
    vecs[4] = mk("wb_through",  i_add(5'd6, 5'd5, 5'd8), 2'b00, 5'd0, 32'h0,    5'd0, 32'h0, 1'b1, 5'd8, 32'h44, 32'h33, 32'h44, 1, 0, 0);
    vecs[5] = mk("x0_zero",     i_add(5'd1, 5'd0, 5'd8), 2'b01, 5'd0, 32'hDEAD, 5'd0, 32'h0, 1'b1, 5'd0, 32'h55, 32'h0,  32'h44, 1, 0, 0);
    vecs[6] = mk("lw_ctrl",     i_lw(5'd9, 5'd8, 12'h010), 2'b00, 5'd0, 32'h0,  5'd0, 32'h0, 1'b0, 5'd0, 32'h0,  32'h44, 32'h0,  1, 1, 0);
    vecs[7] = mk("sw_ctrl",     i_sw(5'd5, 5'd8, 12'h008), 2'b00, 5'd0, 32'h0,  5'd0, 32'h0, 1'b0, 5'd0, 32'h0,  32'h44, 32'h33, 0, 0, 1);

    for (int k = 0; k < 8; k++) begin
      in_valid       = 1'b1;
      in_instruction = vecs[k].instr;
      fwd_valid      = vecs[k].fv;
      fwd_rd_a[0]    = vecs[k].fa0;
      fwd_rd_data[0] = vecs[k].fd0;
      fwd_rd_a[1]    = vecs[k].fa1;
      fwd_rd_data[1] = vecs[k].fd1;
      wb_rd_we       = vecs[k].wbwe;
      wb_rd_a        = vecs[k].wba;
      wb_rd_data     = vecs[k].wbd;
      #1;
      chk({vecs[k].name, "_in_ready"}, in_ready, 1);
      tick();
      chk({vecs[k].name, "_valid"}, out_valid, 1);
      chk({vecs[k].name, "_instr"}, out_instruction, vecs[k].instr);
      chk({vecs[k].name, "_rs1"}, out_rs1_data, vecs[k].e_rs1);
      chk({vecs[k].name, "_rs2"}, out_rs2_data, vecs[k].e_rs2);
      chk({vecs[k].name, "_reg_write"}, out_control_signals.reg_write, vecs[k].e_rw);
      chk({vecs[k].name, "_mem_read"}, out_control_signals.mem_read, vecs[k].e_mr);
      chk({vecs[k].name, "_mem_write"}, out_control_signals.mem_write, vecs[k].e_mw);
      idle_inputs();
      tick();
      chk({vecs[k].name, "_drain"}, out_valid, 0);
    end

    // Load-use: one bubble, then the held instruction passes
    instr_a = i_add(5'd9, 5'd7, 5'd1);
    in_valid = 1'b1; in_instruction = instr_a;
    ex_load_valid = 1'b1; ex_load_rd_a = 5'd7;
    #1;
    chk("lu_in_ready", in_ready, 0);
    tick();
    chk("lu_bubble", out_valid, 0);
    chk("lu_stall_count", stall_count, 1);
    ex_load_valid = 1'b0;
    #1;
    chk("lu_release_ready", in_ready, 1);
    tick();
    chk("lu_pass_valid", out_valid, 1);
    chk("lu_pass_instr", out_instruction, instr_a);
    idle_inputs();
    tick();

    // Backpressure: hold 3 cycles, transfer when out_ready rises
    instr_a = i_add(5'd6, 5'd5, 5'd5);
    instr_b = i_add(5'd2, 5'd8, 5'd8);
    in_valid = 1'b1; in_instruction = instr_a;
    tick();
    chk("bp_fill", out_valid, 1);
    in_instruction = instr_b; out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("bp_in_ready_low", in_ready, 0);
      tick();
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_instr", out_instruction, instr_a);
      chk("bp_hold_rs1", out_rs1_data, 32'h33);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_in_ready_high", in_ready, 1);
    tick();
    chk("bp_xfer_instr", out_instruction, instr_b);
    chk("bp_xfer_rs1", out_rs1_data, 32'h44);

    // Flush together with load-use while FULL
    instr_c = i_add(5'd3, 5'd7, 5'd7);
    in_instruction = instr_c; flush = 1'b1; out_ready = 1'b0;
    ex_load_valid = 1'b1; ex_load_rd_a = 5'd7;
    #1;
    chk("flush_in_ready", in_ready, 0);
    tick();
    chk("flush_valid", out_valid, 0);
    chk("flush_stall_count", stall_count, 2);
    idle_inputs();

    // Reset mid-stream
    in_valid = 1'b1; in_instruction = instr_a;
    tick();
    chk("mid_fill", out_valid, 1);
    in_instruction = instr_b;
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_stall", stall_count, 0);
    tick();
    rst = 1'b1;
    in_valid = 1'b0;
    tick();
    chk("mid_rst_dropped", out_valid, 0);
    in_valid = 1'b1; in_instruction = instr_a;
    tick();
    chk("mid_rst_x5_rs1", out_rs1_data, 0);
    chk("mid_rst_x5_rs2", out_rs2_data, 0);
    idle_inputs();
    tick();

    // Randomized run against the reference model; register file is all zero here
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_valid = 1'b0; m_instr = '0; m_rs1 = '0; m_rs2 = '0; m_stall = 0;
    for (int n = 0; n < 3000; n++) begin
      instr_c = $urandom;
      instr_c[19:15] = 5'($urandom_range(0, 7));
      instr_c[24:20] = 5'($urandom_range(0, 7));
      in_instruction = instr_c;
      in_valid       = ($urandom_range(0, 3) != 0);
      out_ready      = ($urandom_range(0, 3) != 0);
      flush          = ($urandom_range(0, 15) == 0);
      ex_load_valid  = ($urandom_range(0, 3) == 0);
      ex_load_rd_a   = 5'($urandom_range(0, 7));
      fwd_valid      = 2'($urandom_range(0, 3));
      for (int f = 0; f < 2; f++) begin
        fwd_rd_a[f]    = 5'($urandom_range(0, 7));
        fwd_rd_data[f] = $urandom;
      end
      wb_rd_we   = ($urandom_range(0, 1) == 1);
      wb_rd_a    = 5'($urandom_range(0, 7));
      wb_rd_data = $urandom;

      r1  = instr_c[19:15];
      r2  = instr_c[24:20];
      lu  = in_valid && ex_load_valid && (ex_load_rd_a != 0) &&
            ((ex_load_rd_a == r1) || (ex_load_rd_a == r2));
      rdy = (!m_valid || out_ready) && !lu && !flush;
      #1;
      chk("rnd_in_ready", in_ready, rdy);

      if (flush) begin
        m_valid = 1'b0;
      end else if (in_valid && rdy) begin
        m_valid = 1'b1;
        m_instr = instr_c;
        m_rs1   = m_operand(r1);
        m_rs2   = m_operand(r2);
      end else if (!m_valid || out_ready) begin
        m_valid = 1'b0;
      end
      if (lu && m_stall < 65535) m_stall++;
      if (wb_rd_we && wb_rd_a != 0) m_regs[wb_rd_a] = wb_rd_data;

      tick();
      chk("rnd_out_valid", out_valid, m_valid);
      chk("rnd_stall_count", stall_count, 16'(m_stall));
      if (m_valid) begin
        chk("rnd_instr", out_instruction, m_instr);
        chk("rnd_rs1", out_rs1_data, m_rs1);
        chk("rnd_rs2", out_rs2_data, m_rs2);
      end
    end

    // stall_count saturation
    idle_inputs();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    in_valid = 1'b1; in_instruction = i_add(5'd1, 5'd7, 5'd0);
    ex_load_valid = 1'b1; ex_load_rd_a = 5'd7;
    repeat (65540) @(posedge clk);
    #1;
    chk("stall_saturate", stall_count, 16'hFFFF);
    chk("stall_sat_bubble", out_valid, 0);
    idle_inputs();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/kamacore_stage_id_hz.md
KAMACORE_STAGE_ID_HZ -- requirements
Module: kamacore_stage_id_hz

Interface
REQ-001 Parameter CPU_WIDTH, default 32, datapath width in bits.
REQ-002 Parameter REG_ADDR_WIDTH, default 5, register address width.
REQ-003 Parameter NUM_FWD, default 2, number of forwarding channels; index 0 is the youngest stage.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 in_valid / in_ready / in_instruction  in/out/in  1/1/32  IF->ID valid-ready handshake and instruction.
REQ-007 out_valid / out_ready  out/in  1/1  ID->EX handshake.
REQ-008 out_instruction, out_rs1_data, out_rs2_data, out_control_signals  out  32/CPU_WIDTH/CPU_WIDTH/st_control_signals  registered decode outputs.
REQ-009 fwd_valid, fwd_rd_a, fwd_rd_data  in  NUM_FWD x (1/REG_ADDR_WIDTH/CPU_WIDTH)  forwarding channels.
REQ-010 ex_load_valid, ex_load_rd_a  in  1/REG_ADDR_WIDTH  load in EX and its destination.
REQ-011 flush  in  1  discard the held output and the current input.
REQ-012 wb_rd_we, wb_rd_a, wb_rd_data  in  1/REG_ADDR_WIDTH/CPU_WIDTH  register file write port.
REQ-013 stall_count  out  16  saturating count of load-use stall cycles.

Function
REQ-014 Output state SHALL be a two-state FSM: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-015 Transfer SHALL occur when in_valid and in_ready are both high. The output registers load decoded data on the same edge; latency is 1 cycle.
REQ-016 in_ready SHALL equal (EMPTY or out_ready) and not load_use and not flush.
REQ-017 load_use SHALL be: in_valid, ex_load_valid, ex_load_rd_a != 0, and ex_load_rd_a matching instruction[19:15] or [24:20].
REQ-018 On load_use with the output consumed or EMPTY, the FSM SHALL go to EMPTY (bubble). The instruction SHALL be held upstream, not lost.
REQ-019 In FULL with out_ready=0, all out_* registers SHALL hold their values unchanged.
REQ-020 Operand source priority SHALL be:
- register 0 reads zero;
- else the lowest-index fwd channel with fwd_valid and a matching fwd_rd_a;
- else the WB write-through when wb_rd_we and wb_rd_a match;
- else register file data.
REQ-021 Register file writes SHALL be ignored for address 0.
REQ-022 flush SHALL force EMPTY on the next edge, overriding transfer, hold and load_use.
REQ-023 stall_count SHALL increment on each cycle with load_use high and SHALL saturate at 16'hFFFF.
REQ-024 The register file, when read and written on the same edge, SHALL return write-through data via REQ-020.

Reset
REQ-025 Asserting rst SHALL immediately set:
- FSM to EMPTY;
- out_valid, out_instruction, out_rs1_data, out_rs2_data, out_control_signals and stall_count to 0;
- all register file entries to 0.
REQ-026 Reset asserted mid-transfer SHALL drop the in-flight instruction; no output is produced for it.

Structure
REQ-027 CPU_WIDTH, REG_ADDR_WIDTH and st_control_signals SHALL reside in the shared core package.
REQ-028 A sub-module kamacore_operand_mux, one instance per source operand, SHALL implement REQ-020.
REQ-029 The existing kamacore_register_file and kamacore_control_unit SHALL be instantiated unchanged.

Verification
REQ-030 Write x5=0x11 via WB, then issue add x6,x5,x5 -> out_rs1_data = out_rs2_data = 0x11 one cycle after transfer.
REQ-031 Set fwd_valid[0] and fwd_valid[1] both for x5, data 0xA and 0xB -> out_rs1_data = 0xA.
REQ-032 Set ex_load_valid with ex_load_rd_a=x7, instruction reads x7 -> in_ready=0, one bubble (out_valid=0), stall_count=1; instruction passes on the next cycle.
REQ-033 In FULL, hold out_ready=0 for 3 cycles -> outputs stable and in_ready=0; the transfer occurs on the cycle out_ready rises.
REQ-034 Assert flush and load_use in the same cycle while FULL -> out_valid=0 next cycle.
REQ-035 Assert rst mid-stream -> out_valid=0 and stall_count=0 immediately; reading x5 returns 0.
